main_fsm: RTL
=============

# main_fsm

Multicycle control unit for the RV64I core. It sequences each instruction through fetch, decode, execute, memory and write-back states. It replaces the single-cycle combinational opcode decoder, adding a memory ready/request handshake, RV64 word-op gating, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register, the multicycle datapath and the unified memory port.

## Interface
- RV64, default 1: when 1, opcodes 0011011 (OP-IMM-32) and 0111011 (OP-32) are legal; when 0 they trap.
- CNT_W, default 64: width of the retired-instruction counter.
- i_clk  input  1  core clock; all state changes on rising edge.
- i_arst  input  1  reset, asynchronous, active-high.
- i_op  input  7  opcode field from the instruction register; stable from DECODE until the next FETCH.
- i_mem_ready  input  1  memory completes the current request this cycle.
- o_mem_req  output  1  memory request valid.
- o_mem_we  output  1  request is a write.
- o_addr_src  output  1  memory address: 0 = PC, 1 = ALUOut.
- o_instr_we  output  1  load the instruction register and OldPC.
- o_pc_we  output  1  unconditional PC write.
- o_branch  output  1  PC write if the branch condition holds.
- o_reg_we  output  1  register-file write.
- o_imm_src  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- o_alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- o_alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4.
- o_alu_op  output  2  00 add, 01 branch compare/sub, 10 funct-decoded, 11 funct-decoded 32-bit word.
- o_result_src  output  2  00 ALUOut, 01 memory data, 10 ALU result.
- o_illegal  output  1  core is in TRAP.
- o_instret  output  CNT_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, EXEC_RW, EXEC_IW, ALUWB, BRANCH, JAL, JALR, JALR_LINK, LUI, TRAP.
- All outputs default to 0. Each state drives only the outputs listed for it.
- o_imm_src is always decoded combinationally from i_op: loads, OP-IMM, OP-IMM-32 and JALR give I; stores give S; branches give B; JAL gives J; LUI and AUIPC give U. Any other opcode gives I.
- FETCH: mem_req=1, addr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10. When i_mem_ready=1, also assert instr_we=1 and pc_we=1 (Mealy) and go to DECODE. Otherwise stay in FETCH.
- DECODE: src_a=01, src_b=01, alu_op=00, so ALUOut = OldPC+imm. Next state by i_op:
  - loads and stores go to MEMADR.
  - 0110011 goes to EXEC_R; 0010011 goes to EXEC_I.
  - OP-32 goes to EXEC_RW and OP-IMM-32 goes to EXEC_IW, when RV64=1.
  - 1100011 goes to BRANCH; 1101111 goes to JAL; 1100111 goes to JALR; 0110111 goes to LUI.
  - 0010111 (AUIPC) goes to ALUWB.
  - Anything else goes to TRAP.
- MEMADR: src_a=10, src_b=01, alu_op=00. Goes to MEMREAD for loads and MEMWRITE for stores.
- MEMREAD: mem_req=1, addr_src=1. Waits for i_mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_we=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, addr_src=1. Waits for i_mem_ready, then goes to FETCH.
- EXEC_R: src_a=10, src_b=00, alu_op=10. EXEC_I: src_a=10, src_b=01, alu_op=10. The W variants are the same with alu_op=11. All four go to ALUWB.
- ALUWB: result_src=00, reg_we=1. Goes to FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. Goes to FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_we=1. Goes to ALUWB.
- JALR: src_a=10, src_b=01, alu_op=00. Goes to JALR_LINK.
- JALR_LINK: same outputs as JAL. Goes to ALUWB.
- LUI: src_a=11, src_b=01, alu_op=00. Goes to ALUWB.
- TRAP: illegal=1. Stays in TRAP until reset; no memory or register activity.
- o_instret increments by 1 on every transition into FETCH from any state other than FETCH. It wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH and o_instret=0. Outputs while reset is held are the FETCH values with instr_we=0 and pc_we=0 (mem_req=1, src_b=10, result_src=10, all others 0).
- Reset asserted mid-access: the state is dropped immediately. The memory must abandon a pending request when o_mem_req falls or restarts at FETCH.
- Handshake: mem_req, mem_we and addr_src are held constant until the cycle in which i_mem_ready=1. Transfer completes in that cycle. i_mem_ready while mem_req=0 is ignored.
- Cycles with zero-wait memory:
  - loads: 5
  - stores: 4
  - R, I, W, LUI, JALR+link paths: 4, except JALR = 5
  - JAL: 4
  - branch: 3
  - AUIPC: 3
- Each wait cycle adds one cycle.

## Structure
- control_pkg holds:
  - t_state enum;
  - opcode constants;
  - imm-src, alu-src, alu-op and result-src encodings.
- One sub-module, opcode_classifier (combinational): takes i_op and RV64 and returns instruction class, imm_src and a legal flag. main_fsm owns the state register, next-state logic, output decode and counter.

## Test plan
- Reset: assert i_arst mid-MEMREAD with i_mem_ready=0 -> state returns to FETCH asynchronously, o_mem_req=1, o_instret=0.
- ADD (i_op=0110011), ready always 1 -> FETCH, DECODE, EXEC_R, ALUWB; reg_we only in ALUWB; o_instret increments from 0 to 1.
- LW (i_op=0000011) with 2 wait cycles on FETCH and on MEMREAD -> 9 cycles total; addr_src=1 and result_src=01 in MEMWB.
- JALR (i_op=1100111) -> pc_we pulses exactly in JALR_LINK, reg_we in ALUWB; o_imm_src=000 throughout.
- RV64=0, i_op=0111011 -> TRAP after DECODE; o_illegal stays 1 for 20 cycles with no mem_req; RV64=1 -> EXEC_RW with alu_op=11.
- CNT_W=4, 16 back-to-back AUIPC (i_op=0010111) -> o_instret wraps to 0; o_imm_src=100 in DECODE.

Source files
------------

// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared types and encodings for the multicycle RV64I control unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package control_pkg;

   // Controller states
   typedef enum logic [4:0] {
      S_FETCH     = 5'd0,
      S_DECODE    = 5'd1,
      S_MEMADR    = 5'd2,
      S_MEMREAD   = 5'd3,
      S_MEMWB     = 5'd4,
      S_MEMWRITE  = 5'd5,
      S_EXEC_R    = 5'd6,
      S_EXEC_I    = 5'd7,
      S_EXEC_RW   = 5'd8,
      S_EXEC_IW   = 5'd9,
      S_ALUWB     = 5'd10,
      S_BRANCH    = 5'd11,
      S_JAL       = 5'd12,
      S_JALR      = 5'd13,
      S_JALR_LINK = 5'd14,
      S_LUI       = 5'd15,
      S_TRAP      = 5'd16
   } t_state;

   // Instruction classes produced by the opcode classifier
   typedef enum logic [3:0] {
      C_LOAD      = 4'd0,
      C_STORE     = 4'd1,
      C_OP        = 4'd2,
      C_OP_IMM    = 4'd3,
      C_OP_32     = 4'd4,
      C_OP_IMM_32 = 4'd5,
      C_BRANCH    = 4'd6,
      C_JAL       = 4'd7,
      C_JALR      = 4'd8,
      C_LUI       = 4'd9,
      C_AUIPC     = 4'd10,
      C_ILLEGAL   = 4'd11
   } t_class;

   // Major opcodes
   localparam logic [6:0] OPC_LOAD       = 7'b0000011;
   localparam logic [6:0] OPC_STORE      = 7'b0100011;
   localparam logic [6:0] OPC_OP         = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
   localparam logic [6:0] OPC_OP_32      = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
   localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
   localparam logic [6:0] OPC_JAL        = 7'b1101111;
   localparam logic [6:0] OPC_JALR       = 7'b1100111;
   localparam logic [6:0] OPC_LUI        = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC      = 7'b0010111;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU operand A sources
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B sources
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // ALU operation classes
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;
   localparam logic [1:0] ALU_FUNCTW = 2'b11;

   // Write-back result sources
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/opcode_classifier.sv
// ---------------------------------------------------------------------------
// opcode_classifier
// Combinational opcode decode: instruction class, immediate format and a
// legality flag. Word-op opcodes are legal only on an RV64 build.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module opcode_classifier
   import control_pkg::*;
#(
   parameter int RV64 = 1
) (
   input  logic [6:0] op,
   output t_class     cls,
   output logic [2:0] imm_src,
   output logic       legal
);

   localparam bit WORD_OPS = (RV64 != 0);

   // Map the major opcode onto a class and its immediate format
   always_comb begin
      cls     = C_ILLEGAL;
      imm_src = IMM_I;
      case (op)
         OPC_LOAD:      cls = C_LOAD;
         OPC_STORE:     begin cls = C_STORE;  imm_src = IMM_S; end
         OPC_OP:        cls = C_OP;
         OPC_OP_IMM:    cls = C_OP_IMM;
         OPC_OP_32:     if (WORD_OPS) cls = C_OP_32;
         OPC_OP_IMM_32: if (WORD_OPS) cls = C_OP_IMM_32;
         OPC_BRANCH:    begin cls = C_BRANCH; imm_src = IMM_B; end
         OPC_JAL:       begin cls = C_JAL;    imm_src = IMM_J; end
         OPC_JALR:      cls = C_JALR;
         OPC_LUI:       begin cls = C_LUI;    imm_src = IMM_U; end
         OPC_AUIPC:     begin cls = C_AUIPC;  imm_src = IMM_U; end
         default:       cls = C_ILLEGAL;
      endcase
      legal = (cls != C_ILLEGAL);
   end

endmodule

`default_nettype wire

// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm
// Multicycle RV64I control unit: sequences fetch/decode/execute/memory/
// write-back, handshakes with the unified memory port, traps illegal
// opcodes and counts retired instructions.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module main_fsm
   import control_pkg::*;
#(
   parameter int RV64  = 1,
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic [6:0]       i_op,
   input  logic             i_mem_ready,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic             o_addr_src,
   output logic             o_instr_we,
   output logic             o_pc_we,
   output logic             o_branch,
   output logic             o_reg_we,
   output logic [2:0]       o_imm_src,
   output logic [1:0]       o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic [1:0]       o_alu_op,
   output logic [1:0]       o_result_src,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_instret
);

   t_state           state;
   t_state           state_next;
   t_class           cls;
   logic             legal;
   logic [CNT_W-1:0] instret;

   opcode_classifier #(.RV64(RV64)) u_classifier (
      .op      (i_op),
      .cls     (cls),
      .imm_src (o_imm_src),
      .legal   (legal)
   );

   // State register; reset drops any in-flight access and restarts at FETCH
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state <= S_FETCH;
      else        state <= state_next;
   end

   // Next-state and control output decode
   always_comb begin
      state_next   = state;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_addr_src   = 1'b0;
      o_instr_we   = 1'b0;
      o_pc_we      = 1'b0;
      o_branch     = 1'b0;
      o_reg_we     = 1'b0;
      o_alu_src_a  = SRCA_PC;
      o_alu_src_b  = SRCB_RS2;
      o_alu_op     = ALU_ADD;
      o_result_src = RES_ALUOUT;
      o_illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            o_mem_req    = 1'b1;
            o_alu_src_b  = SRCB_FOUR;
            o_result_src = RES_ALU;
            // IR/PC loads are suppressed while reset is held
            if (i_mem_ready && !i_arst) begin
               o_instr_we = 1'b1;
               o_pc_we    = 1'b1;
            end
            if (i_mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            o_alu_src_a = SRCA_OLDPC;
            o_alu_src_b = SRCB_IMM;
            if (!legal) state_next = S_TRAP;
            else begin
               case (cls)
                  C_LOAD, C_STORE: state_next = S_MEMADR;
                  C_OP:            state_next = S_EXEC_R;
                  C_OP_IMM:        state_next = S_EXEC_I;
                  C_OP_32:         state_next = S_EXEC_RW;
                  C_OP_IMM_32:     state_next = S_EXEC_IW;
                  C_BRANCH:        state_next = S_BRANCH;
                  C_JAL:           state_next = S_JAL;
                  C_JALR:          state_next = S_JALR;
                  C_LUI:           state_next = S_LUI;
                  C_AUIPC:         state_next = S_ALUWB;
                  default:         state_next = S_TRAP;
               endcase
            end
         end
         S_MEMADR: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_IMM;
            state_next  = (cls == C_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            o_mem_req  = 1'b1;
            o_addr_src = 1'b1;
            if (i_mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            o_result_src = RES_MEM;
            o_reg_we     = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMWRITE: begin
            o_mem_req  = 1'b1;
            o_mem_we   = 1'b1;
            o_addr_src = 1'b1;
            if (i_mem_ready) state_next = S_FETCH;
         end
         S_EXEC_R, S_EXEC_I, S_EXEC_RW, S_EXEC_IW: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = (state == S_EXEC_I || state == S_EXEC_IW) ? SRCB_IMM : SRCB_RS2;
            o_alu_op    = (state == S_EXEC_RW || state == S_EXEC_IW) ? ALU_FUNCTW : ALU_FUNCT;
            state_next  = S_ALUWB;
         end
         S_ALUWB: begin
            o_result_src = RES_ALUOUT;
            o_reg_we     = 1'b1;
            state_next   = S_FETCH;
         end
         S_BRANCH: begin
            o_alu_src_a  = SRCA_RS1;
            o_alu_src_b  = SRCB_RS2;
            o_alu_op     = ALU_SUB;
            o_result_src = RES_ALUOUT;
            o_branch     = 1'b1;
            state_next   = S_FETCH;
         end
         S_JAL, S_JALR_LINK: begin
            // PC <- ALUOut (target), ALUOut <- OldPC+4 for the link write
            o_alu_src_a  = SRCA_OLDPC;
            o_alu_src_b  = SRCB_FOUR;
            o_result_src = RES_ALUOUT;
            o_pc_we      = 1'b1;
            state_next   = S_ALUWB;
         end
         S_JALR: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_IMM;
            state_next  = S_JALR_LINK;
         end
         S_LUI: begin
            o_alu_src_a = SRCA_ZERO;
            o_alu_src_b = SRCB_IMM;
            state_next  = S_ALUWB;
         end
         S_TRAP: begin
            o_illegal  = 1'b1;
            state_next = S_TRAP;
         end
         default: state_next = S_TRAP;
      endcase
   end

   // Retired-instruction counter: one count per return to FETCH
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)
         instret <= '0;
      else if (state != S_FETCH && state_next == S_FETCH)
         instret <= instret + CNT_W'(1);
   end

   assign o_instret = instret;

endmodule

`default_nettype wire
